sprite_motion_ctrl: RTL and testbench
=====================================

# sprite_motion_ctrl

Per-frame sprite position controller for the sprite test top level. It takes the four raw direction keys, synchronizes and debounces them, and steps a sprite (X,Y) position once per video frame on the rising edge of vsync, clamped to the visible area. It drives the position inputs of the sprite renderer in the pixel-clock domain. Both coordinates change in the same cycle, so the renderer never sees a half-updated position.

## Interface
Parameters:
- H_ACTIVE, 256: visible width in pixels.
- V_ACTIVE, 240: visible height in lines.
- SPRITE_W, 16 / SPRITE_H, 16: sprite size.
- STEP, 1: pixels moved per frame per axis.
- X_INIT, 120 / Y_INIT, 112: position after reset.
- DEBOUNCE_CYCLES, 16: stable cycles required to accept a key change.
- POS_W, 9: coordinate width.

Ports:
- clk  in  1  pixel clock, the same clock as the sync generator.
- reset  in  1  asynchronous, active-high.
- keys  in  4  raw buttons, asynchronous, active-high; [0]=left, [1]=right, [2]=up, [3]=down.
- vsync  in  1  vertical sync from the sync generator, active-high, synchronous to clk.
- enable  in  1  motion enable, sampled at the vsync edge.
- sprite_x  out  POS_W  sprite left edge.
- sprite_y  out  POS_W  sprite top edge.
- updated  out  1  one-cycle pulse when a new position is committed.
- keys_db  out  4  debounced key state.

## Operation
- Key path: each key passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer has a counter and a stable state.
  - While the synchronized value differs from the stable state, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, the stable state flips and the counter clears.
  - Any cycle where the synchronized value equals the stable state clears the counter.
- Frame edge: vsync is registered into vsync_d. edge = vsync & ~vsync_d.
- FSM states: WAIT, CALC, CLAMP, COMMIT.
  - WAIT -> CALC on edge & enable. If enable=0 at the edge, stay in WAIT.
  - CALC: latch keys_db. Compute dx and dy:
    - dx = -STEP for left only, +STEP for right only, 0 for neither or both.
    - dy = -STEP for up only, +STEP for down only, 0 for neither or both.
    - Form nx = sprite_x + dx and ny = sprite_y + dy in signed POS_W+1 arithmetic.
  - CLAMP: nx<0 -> 0; nx>H_ACTIVE-SPRITE_W -> H_ACTIVE-SPRITE_W. Same rule for ny with V_ACTIVE-SPRITE_H.
  - COMMIT: write sprite_x and sprite_y together. Assert updated. Return to WAIT.
- updated pulses on every commit, including commits where the position is unchanged.
- Edges seen outside WAIT are ignored; they are not queued.
- Reset values:
  - sprite_x=X_INIT, sprite_y=Y_INIT.
  - updated=0, keys_db=0.
  - State WAIT, all debounce counters 0, vsync_d=0.
- Reset mid-sequence (CALC, CLAMP or COMMIT) aborts the update: the registers take their reset values and no updated pulse is produced.

## Timing
- Key latency: a raw key change held steady appears on keys_db 2 + DEBOUNCE_CYCLES cycles later.
- Let E be the cycle in which edge is high.
  - State is CALC in E+1, CLAMP in E+2, COMMIT in E+3.
  - The new sprite_x/sprite_y and updated=1 are visible in E+4.
  - updated is high for exactly one cycle.
- Keys are sampled in E+1. A key change after E+1 applies from the next frame.
- At most one update per vsync rising edge. A vsync held high produces a single edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package sprite_ctrl_pkg holds:
  - the FSM state enum (WAIT, CALC, CLAMP, COMMIT);
  - the key index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_UP=2, KEY_DOWN=3.
- Sub-module key_debounce contains the synchronizer, counter and stable state, parameterized by DEBOUNCE_CYCLES. Four instances are used.
- The top-level sprite test instantiates sprite_motion_ctrl on the divided pixel clock and feeds sprite_x/sprite_y to the sprite renderer.

## Test plan
- Reset, with no frame edge afterwards -> sprite_x=120, sprite_y=112, updated=0, keys_db=0.
- Right held past debounce, then 3 vsync edges -> sprite_x goes 121, 122, 123; each value appears in E+4 with a 1-cycle updated pulse; sprite_y stays 112.
- Position x=0 with left held, 2 edges -> x stays 0, updated still pulses. Position x=239 with right held, 3 edges -> 240, 240, 240.
- Left and right held together plus up, 1 edge -> x unchanged, y 112->111. With enable=0 at the edge -> no change and no pulse.
- Right glitch of 10 cycles (DEBOUNCE_CYCLES=16) around an edge -> keys_db stays 0, x unchanged.
- Reset asserted during CLAMP -> outputs return to 120/112 immediately, no updated pulse; the next edge after reset release operates normally.

Source files
------------

// File: rtl/sprite_ctrl_pkg.sv
// sprite_ctrl_pkg: shared FSM state encoding and key bit positions for the sprite motion controller.
// Revision: 1.0
`default_nettype none

package sprite_ctrl_pkg;

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      CALC   = 2'd1,
      CLAMP  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   localparam int KEY_LEFT  = 0;
   localparam int KEY_RIGHT = 1;
   localparam int KEY_UP    = 2;
   localparam int KEY_DOWN  = 3;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer followed by a stable-count debouncer for one raw key.
// Revision: 1.0
`default_nettype none

module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         count  <= '0;
         stable <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         if (sync_2 == stable) begin
            count <= '0;
         end else if (count == CNT_LAST) begin
            // DEBOUNCE_CYCLES consecutive disagreeing samples accept the change
            stable <= ~stable;
            count  <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: debounced key input steps a clamped sprite position once per vsync rising edge.
// Revision: 1.0
`default_nettype none

module sprite_motion_ctrl
   import sprite_ctrl_pkg::*;
#(
   parameter int H_ACTIVE        = 256,
   parameter int V_ACTIVE        = 240,
   parameter int SPRITE_W        = 16,
   parameter int SPRITE_H        = 16,
   parameter int STEP            = 1,
   parameter int X_INIT          = 120,
   parameter int Y_INIT          = 112,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int POS_W           = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       keys,
   input  logic             vsync,
   input  logic             enable,
   output logic [POS_W-1:0] sprite_x,
   output logic [POS_W-1:0] sprite_y,
   output logic             updated,
   output logic [3:0]       keys_db
);

   localparam logic signed [POS_W:0] STEP_S = (POS_W+1)'(STEP);
   localparam logic signed [POS_W:0] MAX_X_S = (POS_W+1)'(H_ACTIVE - SPRITE_W);
   localparam logic signed [POS_W:0] MAX_Y_S = (POS_W+1)'(V_ACTIVE - SPRITE_H);
   localparam logic [POS_W-1:0] MAX_X = POS_W'(H_ACTIVE - SPRITE_W);
   localparam logic [POS_W-1:0] MAX_Y = POS_W'(V_ACTIVE - SPRITE_H);
   localparam logic [POS_W-1:0] X_RST = POS_W'(X_INIT);
   localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_INIT);

   logic [3:0] db;

   generate
      for (genvar i = 0; i < 4; i++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_key_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (keys[i]),
            .stable(db[i])
         );
      end
   endgenerate

   assign keys_db = db;

   logic   vsync_d;
   logic   frame_edge;
   state_t state;
   state_t state_next;

   assign frame_edge = vsync & ~vsync_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_d <= 1'b0;
         state   <= WAIT;
      end else begin
         vsync_d <= vsync;
         state   <= state_next;
      end
   end

   // Edges arriving while an update is in flight are dropped, not queued
   always_comb begin
      state_next = state;
      case (state)
         WAIT:    if (frame_edge && enable) state_next = CALC;
         CALC:    state_next = CLAMP;
         CLAMP:   state_next = COMMIT;
         COMMIT:  state_next = WAIT;
         default: state_next = WAIT;
      endcase
   end

   logic signed [POS_W:0] dx;
   logic signed [POS_W:0] dy;
   logic signed [POS_W:0] sum_x;
   logic signed [POS_W:0] sum_y;
   logic signed [POS_W:0] nx;
   logic signed [POS_W:0] ny;
   logic [POS_W-1:0]      clamp_x;
   logic [POS_W-1:0]      clamp_y;
   logic [POS_W-1:0]      cx;
   logic [POS_W-1:0]      cy;

   // Opposing keys held together cancel on that axis
   always_comb begin
      dx = '0;
      dy = '0;
      if (db[KEY_LEFT] && !db[KEY_RIGHT]) dx = -STEP_S;
      else if (db[KEY_RIGHT] && !db[KEY_LEFT]) dx = STEP_S;
      if (db[KEY_UP] && !db[KEY_DOWN]) dy = -STEP_S;
      else if (db[KEY_DOWN] && !db[KEY_UP]) dy = STEP_S;
      sum_x = signed'({1'b0, sprite_x}) + dx;
      sum_y = signed'({1'b0, sprite_y}) + dy;
   end

   always_comb begin
      clamp_x = nx[POS_W-1:0];
      clamp_y = ny[POS_W-1:0];
      if (nx[POS_W]) clamp_x = '0;
      else if (nx > MAX_X_S) clamp_x = MAX_X;
      if (ny[POS_W]) clamp_y = '0;
      else if (ny > MAX_Y_S) clamp_y = MAX_Y;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nx       <= '0;
         ny       <= '0;
         cx       <= '0;
         cy       <= '0;
         sprite_x <= X_RST;
         sprite_y <= Y_RST;
         updated  <= 1'b0;
      end else begin
         updated <= 1'b0;
         case (state)
            CALC: begin
               nx <= sum_x;
               ny <= sum_y;
            end
            CLAMP: begin
               cx <= clamp_x;
               cy <= clamp_y;
            end
            COMMIT: begin
               sprite_x <= cx;
               sprite_y <= cy;
               updated  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed stimulus, per-cycle comparison against a frame-level behavioural model.
// Revision: 1.0
`default_nettype none

module tb_sprite_motion_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] keys = 4'd0;
   logic       vsync = 1'b0;
   logic       enable = 1'b1;
   logic [8:0] sprite_x;
   logic [8:0] sprite_y;
   logic       updated;
   logic [3:0] keys_db;

   int checks = 0;
   int failures = 0;
   bit checking = 1'b0;

   sprite_motion_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .keys    (keys),
      .vsync   (vsync),
      .enable  (enable),
      .sprite_x(sprite_x),
      .sprite_y(sprite_y),
      .updated (updated),
      .keys_db (keys_db)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         mx, my;
   bit         mupd;
   logic [3:0] mdb;
   logic [3:0] mraw_d1, mraw_d2;
   logic [3:0] win [16];
   bit         mprev_v;
   int         mage;
   int         tx, ty;

   function automatic int axis_step(input logic neg, input logic pos);
      if (neg && !pos) return -1;
      if (pos && !neg) return 1;
      return 0;
   endfunction

   function automatic int limit(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mx = 120; my = 112; mupd = 0; mdb = 4'd0;
         mraw_d1 = 4'd0; mraw_d2 = 4'd0; mprev_v = 0; mage = 0;
         for (int i = 0; i < 16; i++) win[i] = 4'd0;
      end else begin
         mupd = 0;
         // a request accepted at edge cycle E reads keys in E+1 and lands after E+3
         if (mage == 1) begin
            tx = limit(mx + axis_step(mdb[0], mdb[1]), 240);
            ty = limit(my + axis_step(mdb[2], mdb[3]), 224);
         end
         if (mage == 3) begin
            mx = tx; my = ty; mupd = 1;
         end
         if (mage == 0) mage = (vsync && !mprev_v && enable) ? 1 : 0;
         else mage = (mage == 3) ? 0 : mage + 1;
         mprev_v = vsync;
         // a key is accepted once its synchronized value disagrees for 16 samples in a row
         for (int i = 15; i > 0; i--) win[i] = win[i-1];
         win[0] = mraw_d2;
         for (int k = 0; k < 4; k++) begin
            bit all_diff;
            all_diff = 1;
            for (int i = 0; i < 16; i++) if (win[i][k] == mdb[k]) all_diff = 0;
            if (all_diff) mdb[k] = ~mdb[k];
         end
         mraw_d2 = mraw_d1;
         mraw_d1 = keys;
      end
   end

   always @(posedge clk) begin
      #1;
      if (checking && !reset) begin
         check("model_x", int'(sprite_x), mx);
         check("model_y", int'(sprite_y), my);
         check("model_updated", int'(updated), int'(mupd));
         check("model_keys_db", int'(keys_db), int'(mdb));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_edge(input bit chk, input int ex, input int ey, input bit eu);
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (chk) begin
         check("edge_updated", int'(updated), int'(eu));
         check("edge_x", int'(sprite_x), ex);
         check("edge_y", int'(sprite_y), ey);
      end
      @(posedge clk);
      #1;
      if (chk) check("pulse_width", int'(updated), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic hold_keys(input logic [3:0] k);
      @(negedge clk); keys = k;
      repeat (25) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checking = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_x", int'(sprite_x), 120);
      check("rst_y", int'(sprite_y), 112);
      check("rst_updated", int'(updated), 0);
      check("rst_keys_db", int'(keys_db), 0);

      hold_keys(4'b0010);
      check("db_right", int'(keys_db), 2);
      do_edge(1, 121, 112, 1);
      do_edge(1, 122, 112, 1);
      do_edge(1, 123, 112, 1);

      hold_keys(4'b0001);
      for (int i = 0; i < 123; i++) do_edge(0, 0, 0, 0);
      check("walk_left_x", int'(sprite_x), 0);
      do_edge(1, 0, 112, 1);
      do_edge(1, 0, 112, 1);

      hold_keys(4'b0010);
      for (int i = 0; i < 239; i++) do_edge(0, 0, 0, 0);
      check("walk_right_x", int'(sprite_x), 239);
      do_edge(1, 240, 112, 1);
      do_edge(1, 240, 112, 1);
      do_edge(1, 240, 112, 1);

      hold_keys(4'b0111);
      do_edge(1, 240, 111, 1);
      enable = 1'b0;
      do_edge(1, 240, 111, 0);
      enable = 1'b1;

      hold_keys(4'b0000);
      @(negedge clk); keys = 4'b0010;
      repeat (3) @(negedge clk);
      vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
      repeat (6) @(negedge clk);
      keys = 4'b0000;
      repeat (20) @(negedge clk);
      check("glitch_keys_db", int'(keys_db), 0);
      check("glitch_x", int'(sprite_x), 240);
      check("glitch_y", int'(sprite_y), 111);

      hold_keys(4'b0010);
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
      @(negedge clk); reset = 1'b1;
      #1;
      check("abort_x", int'(sprite_x), 120);
      check("abort_y", int'(sprite_y), 112);
      check("abort_updated", int'(updated), 0);
      repeat (3) @(negedge clk);
      check("abort_no_pulse", int'(updated), 0);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      do_edge(1, 121, 112, 1);

      checking = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
